// File: rtl/eq_window_ctrl.sv
// Windowed equal-half counter: counts samples whose in[3:2] equals in[1:0]
// over a bounded, abortable window and returns the result through valid/ready.
//
// state | meaning
// IDLE  | waiting for start with a non-zero window length
// RUN   | consuming valid samples until the window is exhausted or aborted
// DONE  | result held on res_* until res_valid && res_ready
module eq_window_ctrl #(
    parameter int WIN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIN_W-1:0] win_len_i,
    input  logic             abort_i,
    input  logic             in_valid_i,
    input  logic [3:0]       in_i,
    output logic             busy_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [CNT_W-1:0] res_cnt_o,
    output logic [WIN_W-1:0] res_samples_o,
    output logic             res_sat_o,
    output logic             res_aborted_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIN_W-1:0]   remaining_q, remaining_d;
    logic [WIN_W-1:0]   samples_q, samples_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               aborted_q, aborted_d;
    logic               match;

    assign match = (in_i[3:2] == in_i[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            samples_q   <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            samples_q   <= samples_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            aborted_q   <= aborted_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        samples_d   = samples_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        aborted_d   = aborted_q;
        unique case (state_q)
            IDLE: begin
                if (start_i && (win_len_i != '0)) begin
                    remaining_d = win_len_i;
                    samples_d   = '0;
                    cnt_d       = '0;
                    sat_d       = 1'b0;
                    aborted_d   = 1'b0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                // Abort wins over a sample presented in the same cycle.
                if (abort_i) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (in_valid_i) begin
                    remaining_d = remaining_q - WIN_W'(1);
                    samples_d   = samples_q + WIN_W'(1);
                    if (match) begin
                        if (cnt_q == '1) begin
                            sat_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    if (remaining_q == WIN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o        = (state_q != IDLE);
    assign res_valid_o   = (state_q == DONE);
    assign res_cnt_o     = cnt_q;
    assign res_samples_o = samples_q;
    assign res_sat_o     = sat_q;
    assign res_aborted_o = aborted_q;

endmodule

// File: tb/tb_eq_window_ctrl.sv
// Scoreboard bench for eq_window_ctrl: two instances (CNT_W=8 and CNT_W=2)
// share one stimulus stream so saturation is exercised alongside normal counting.
module tb_eq_window_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] win_len;
    logic       abort;
    logic       in_valid;
    logic [3:0] in_nib;
    logic       res_ready;

    logic       busy8, rv8, sat8, ab8;
    logic [7:0] cnt8, smp8;
    logic       busy2, rv2, sat2, ab2;
    logic [1:0] cnt2;
    logic [7:0] smp2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int cnt8;
        int sat8;
        int cnt2;
        int sat2;
        int samples;
        int aborted;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    bit         have_cur = 0;
    logic [3:0] smp[$];

    eq_window_ctrl #(.WIN_W(8), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .win_len_i(win_len),
        .abort_i(abort), .in_valid_i(in_valid), .in_i(in_nib),
        .busy_o(busy8), .res_valid_o(rv8), .res_ready_i(res_ready),
        .res_cnt_o(cnt8), .res_samples_o(smp8), .res_sat_o(sat8),
        .res_aborted_o(ab8)
    );

    eq_window_ctrl #(.WIN_W(8), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .win_len_i(win_len),
        .abort_i(abort), .in_valid_i(in_valid), .in_i(in_nib),
        .busy_o(busy2), .res_valid_o(rv2), .res_ready_i(res_ready),
        .res_cnt_o(cnt2), .res_samples_o(smp2), .res_sat_o(sat2),
        .res_aborted_o(ab2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Result monitor: every DONE cycle is compared, so held values are verified too.
    always @(negedge clk) begin
        if (rv8 || rv2) begin
            if (!have_cur) begin
                chk("sb_has_entry", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    have_cur = 1;
                end
            end
            if (have_cur) begin
                chk("rv_pair", rv2, rv8);
                chk("cnt8", cnt8, cur.cnt8);
                chk("sat8", sat8, cur.sat8);
                chk("cnt2", cnt2, cur.cnt2);
                chk("sat2", sat2, cur.sat2);
                chk("samples8", smp8, cur.samples);
                chk("samples2", smp2, cur.samples);
                chk("aborted8", ab8, cur.aborted);
                chk("aborted2", ab2, cur.aborted);
                if (res_ready) have_cur = 0;
            end
        end
    end

    task automatic idle_inputs();
        start = 0; win_len = 0; abort = 0; in_valid = 0; in_nib = 0; res_ready = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {busy8, busy2}, 0);
        chk({tag, "_valid"}, {rv8, rv2}, 0);
        chk({tag, "_cnt"}, {cnt8, 6'd0, cnt2}, 0);
        chk({tag, "_samples"}, {smp8, smp2}, 0);
        chk({tag, "_flags"}, {sat8, sat2, ab8, ab2}, 0);
    endtask

    // Runs one window over smp[]; abort_at is the index of the valid sample
    // carrying abort (-1 for none); gaps inserts an idle cycle between samples.
    task automatic run_window(input int len, input bit gaps, input int abort_at, input int ready_wait);
        exp_t e;
        int   n;
        int   edges;
        int   acc;
        bit   last;
        e = '{default: 0};
        n = 0;
        for (int k = 0; k < len; k++) begin
            if (k == abort_at) begin
                e.aborted = 1;
                break;
            end
            n++;
            if (smp[k][3:2] == smp[k][1:0]) begin
                if (e.cnt8 == 255) e.sat8 = 1; else e.cnt8++;
                if (e.cnt2 == 3) e.sat2 = 1; else e.cnt2++;
            end
        end
        e.samples = n;
        sb.push_back(e);
        edges = (abort_at >= 0 && abort_at < len) ? abort_at + 1 : len;
        if (gaps) edges = edges + edges - 1;

        @(posedge clk); #1;
        start = 1; win_len = len[7:0];
        @(posedge clk); #1;
        start = 0;
        acc = cyc;
        chk("busy_after_start", {busy8, busy2}, 2'b11);
        for (int k = 0; k < len; k++) begin
            if (gaps && k > 0) begin
                in_valid = 0; in_nib = 4'($urandom); start = (k == 1); win_len = 7;
                @(posedge clk); #1;
                start = 0;
            end
            last = (k == len - 1) || (k == abort_at);
            if (last) chk("valid_early", {rv8, rv2}, 0);
            in_valid = 1; in_nib = smp[k]; abort = (k == abort_at);
            @(posedge clk); #1;
            if (k == abort_at) break;
        end
        in_valid = 0; abort = 0;
        chk("valid_rise", {rv8, rv2}, 2'b11);
        chk("latency", cyc - acc, edges);
        for (int w = 0; w < ready_wait; w++) begin
            in_valid = 1; in_nib = 4'($urandom); start = 1; win_len = 3; abort = 1;
            @(posedge clk); #1;
        end
        // Start during the handshake cycle must be ignored.
        res_ready = 1; start = 1; win_len = 3; in_valid = 1; abort = 0;
        @(posedge clk); #1;
        idle_inputs();
        chk("valid_drop", {rv8, rv2}, 0);
        chk("busy_drop", {busy8, busy2}, 0);
        smp.delete();
    endtask

    initial begin
        int len;
        idle_inputs();
        rst_n = 0;
        #22 rst_n = 1;
        #1 chk_all_zero("reset");

        // Reset in the middle of a window.
        @(posedge clk); #1;
        start = 1; win_len = 5;
        @(posedge clk); #1;
        start = 0; in_valid = 1; in_nib = 4'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 0;
        chk("pre_reset_samples", smp8, 2);
        rst_n = 0;
        #1 chk_all_zero("midrun_reset");
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        chk_all_zero("after_reset");

        smp = '{4'h0, 4'h1, 4'h5};
        run_window(3, 0, -1, 0);

        smp = '{4'h5, 4'h6, 4'hF, 4'h0};
        run_window(4, 0, -1, 1);

        smp = '{4'h5, 4'h6, 4'hF, 4'h0};
        run_window(4, 1, -1, 0);

        for (int i = 0; i < 10; i++) smp.push_back(4'hA);
        run_window(10, 0, 5, 0);

        smp = '{4'h0, 4'h5, 4'hA, 4'hF, 4'h5, 4'hA};
        run_window(6, 0, -1, 5);

        // Zero-length start is ignored.
        @(posedge clk); #1;
        start = 1; win_len = 0;
        @(posedge clk); #1;
        start = 0;
        chk("zero_len_busy", {busy8, busy2}, 0);

        smp = '{4'h0};
        run_window(1, 0, -1, 0);

        smp = '{4'hF, 4'h3};
        run_window(2, 0, 0, 0);

        for (int i = 0; i < 255; i++) smp.push_back(4'h0);
        run_window(255, 0, -1, 0);

        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) smp.push_back(4'($urandom));
            run_window(len, r[0], (r == 2) ? $urandom_range(0, len - 1) : -1, r);
        end

        repeat (2) @(posedge clk);
        #1 chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
